// File: rtl/conv_pkg.sv
// Shared types and index helpers for the convolution window generator.
// Holds the FSM states, the stride encoding and the tap/lane index helpers.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        STRIDE_1 = 1'b0,
        STRIDE_2 = 1'b1
    } stride_t;

    // Tap index inside one K x K window: row-major, row 0 / column 0 oldest.
    function automatic int tap_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

    // Output lane of a tap of a given channel.
    function automatic int lane_idx(input int ch, input int t, input int k);
        return ch * k * k + t;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port line memory: one write and one registered read per cycle.
// Contents are deliberately left unreset so the array maps onto block RAM.
module line_buffer_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming K x K sliding-window generator over CH_NUM parallel channels,
// with stride 1/2, a pointwise bypass mode and a registered output stage.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int CH_NUM     = 18,
    parameter int DATA_WIDTH = 8,
    parameter int K          = 3,
    parameter int MAX_LINE   = 512,
    parameter int LW         = $clog2(MAX_LINE + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CH_NUM*DATA_WIDTH-1:0]         s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic [CH_NUM*K*K*DATA_WIDTH-1:0]     m_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    input  logic [LW-1:0]                        cfg_line_len,
    input  logic [LW-1:0]                        cfg_rows,
    input  logic                                 cfg_stride,
    input  logic                                 cfg_pw,
    input  logic                                 cfg_start,
    output logic                                 busy,
    output logic                                 done
);

    localparam int PIX_W = CH_NUM * DATA_WIDTH;
    localparam int KK    = K * K;
    localparam int MW    = CH_NUM * KK * DATA_WIDTH;
    localparam int AW    = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
    localparam int HW    = (K > 1) ? CH_NUM * K * (K - 1) * DATA_WIDTH : DATA_WIDTH;
    localparam logic [LW-1:0] ONE = LW'(1);
    localparam logic [LW-1:0] KM1 = LW'(K - 1);

    state_t            state_reg, state_next;
    stride_t           stride_reg;
    logic              pw_reg;
    logic [LW-1:0]     len_reg, rows_reg, col_reg, row_reg, col_next;
    logic [HW-1:0]     hist_reg, hist_next;
    logic [MW-1:0]     win_next, m_data_reg, m_data_next;
    logic              m_valid_reg;
    logic              s_fire, drain, last_col, last_pix, win_hit;
    logic [AW-1:0]     rd_addr;
    logic [PIX_W-1:0]  col_vec [K];

    assign drain    = !m_valid_reg || m_ready;
    assign s_fire   = s_valid && s_ready;
    assign last_col = (col_reg == len_reg - ONE);
    assign last_pix = last_col && (row_reg == rows_reg - ONE);
    assign col_next = last_col ? '0 : col_reg + ONE;
    // Read one pixel ahead so the registered RAM output lines up with the next beat.
    assign rd_addr  = s_fire ? col_next[AW-1:0] : col_reg[AW-1:0];

    assign win_hit = pw_reg ||
                     ((row_reg >= KM1) && (col_reg >= KM1) &&
                      ((stride_reg == STRIDE_1) ||
                       ((row_reg[0] == KM1[0]) && (col_reg[0] == KM1[0]))));

    // col_vec[K-1] is the incoming row; line buffer gi delivers the row gi+1 older.
    assign col_vec[K-1] = s_data;
    for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
        line_buffer_ram #(
            .DEPTH (MAX_LINE),
            .WIDTH (PIX_W),
            .AW    (AW)
        ) u_lb (
            .clk     (clk),
            .we      (s_fire && !pw_reg),
            .wr_addr (col_reg[AW-1:0]),
            .wr_data (col_vec[K-1-gi]),
            .rd_addr (rd_addr),
            .rd_data (col_vec[K-2-gi])
        );
    end

    // Only the K-1 newest columns are stored; the newest column arrives with the beat.
    if (K == 1) begin : g_no_hist
        assign hist_next = '0;
    end
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        for (genvar gr = 0; gr < K; gr++) begin : g_row
            for (genvar gc = 0; gc < K; gc++) begin : g_col
                localparam int LANE = lane_idx(gi, tap_idx(gr, gc, K), K);
                localparam int HIST = (gi * K + gr) * (K - 1) + gc;
                if (gc == K - 1) begin : g_new
                    assign win_next[LANE*DATA_WIDTH +: DATA_WIDTH] =
                        col_vec[gr][gi*DATA_WIDTH +: DATA_WIDTH];
                end else begin : g_old
                    assign win_next[LANE*DATA_WIDTH +: DATA_WIDTH] =
                        hist_reg[HIST*DATA_WIDTH +: DATA_WIDTH];
                end
                if (gc > 0) begin : g_keep
                    assign hist_next[(HIST-1)*DATA_WIDTH +: DATA_WIDTH] =
                        win_next[LANE*DATA_WIDTH +: DATA_WIDTH];
                end
                if (gr == 0 && gc == 0) begin : g_tap0
                    assign m_data_next[LANE*DATA_WIDTH +: DATA_WIDTH] = pw_reg ?
                        s_data[gi*DATA_WIDTH +: DATA_WIDTH] : win_next[LANE*DATA_WIDTH +: DATA_WIDTH];
                end else begin : g_tapn
                    assign m_data_next[LANE*DATA_WIDTH +: DATA_WIDTH] = pw_reg ?
                        {DATA_WIDTH{1'b0}} : win_next[LANE*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (cfg_start) state_next = ST_RUN;
            ST_RUN:  if (s_fire && last_pix) state_next = ST_DONE;
            ST_DONE: if (drain) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        if (!rst) begin
            s_ready = (state_reg == ST_RUN) && drain;
            busy    = (state_reg != ST_IDLE);
            done    = (state_reg == ST_DONE) && drain;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_reg     <= '0;
            rows_reg    <= '0;
            col_reg     <= '0;
            row_reg     <= '0;
            stride_reg  <= STRIDE_1;
            pw_reg      <= 1'b0;
            hist_reg    <= '0;
            m_data_reg  <= '0;
            m_valid_reg <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && cfg_start) begin
                len_reg    <= cfg_line_len;
                rows_reg   <= cfg_rows;
                stride_reg <= stride_t'(cfg_stride);
                pw_reg     <= cfg_pw;
                col_reg    <= '0;
                row_reg    <= '0;
            end
            if (s_fire) begin
                col_reg     <= col_next;
                if (last_col) begin
                    row_reg <= last_pix ? '0 : row_reg + ONE;
                end
                m_valid_reg <= win_hit;
                if (win_hit) begin
                    m_data_reg <= m_data_next;
                end
                if (!pw_reg) begin
                    hist_reg <= hist_next;
                end
            end else if (m_ready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter CH_NUM, default 18, number of parallel channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per pixel.
REQ-003 SHALL have parameter K, default 3, square kernel size, legal range 1..5.
REQ-004 SHALL have parameter MAX_LINE, default 512, maximum line length in pixels.
REQ-005 SHALL have parameter LW, default clog2(MAX_LINE+1), width of the line and row counters.
REQ-006 SHALL have port clk, input, 1, the only clock.
REQ-007 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-008 SHALL have port s_data, input, CH_NUM*DATA_WIDTH, one pixel per channel; channel c is at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have ports s_valid (input, 1) and s_ready (output, 1), the input handshake.
REQ-010 SHALL have port m_data, output, CH_NUM*K*K*DATA_WIDTH, the window; tap t=r*K+c of channel ch is at lane (ch*K*K+t); r=0 is the oldest row, c=0 the oldest column.
REQ-011 SHALL have ports m_valid (output, 1) and m_ready (input, 1), the output handshake.
REQ-012 SHALL have config inputs cfg_line_len [LW], cfg_rows [LW], cfg_stride [1] (0 = stride 1, 1 = stride 2) and cfg_pw [1] (1 = pointwise mode).
REQ-013 SHALL have cfg_start (input, 1), busy (output, 1) and done (output, 1, single-cycle pulse).

Function
REQ-014 SHALL implement FSM IDLE -> RUN on cfg_start; RUN -> DONE after the pixel at (row cfg_rows-1, col cfg_line_len-1) is accepted; DONE -> IDLE after the last output handshake completes.
REQ-015 SHALL latch all cfg_* inputs on cfg_start in IDLE; cfg_start SHALL be ignored outside IDLE.
REQ-016 SHALL assert busy in RUN and DONE.
REQ-017 SHALL pulse done for exactly one cycle on the DONE -> IDLE transition.
REQ-018 SHALL transfer a beat when valid && ready, on both interfaces.
REQ-019 SHALL drive s_ready = (state==RUN) && (!m_valid || m_ready); no input beat is lost or duplicated under any backpressure.
REQ-020 SHALL, in DW mode, keep K-1 line buffers per channel of depth cfg_line_len, plus a K x K shift window per channel.
REQ-021 SHALL assert m_valid for a window only when row>=K-1, col>=K-1, (row-K+1)%S==0 and (col-K+1)%S==0, where S is the stride.
REQ-022 SHALL register the output, giving a latency of exactly 1 cycle from the accepting input beat to m_valid.
REQ-023 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-024 SHALL, in PW mode, emit one output per accepted input: tap 0 of each channel = pixel, other taps = 0, line buffers bypassed, stride ignored.
REQ-025 SHALL wrap the column counter at cfg_line_len-1 to 0 and increment the row counter; the line-buffer read/write pointer SHALL wrap at the same point.
REQ-026 SHALL, when cfg_line_len < K or cfg_rows < K in DW mode, accept all pixels, emit no windows, and still pulse done.
REQ-027 SHALL let window contents in a new frame depend only on that frame's pixels; stale line-buffer data is never emitted.
REQ-028 SHALL pass pixel values unmodified; no arithmetic is applied to data.

Reset
REQ-029 SHALL, on rst, force state=IDLE, s_ready=0, m_valid=0, busy=0, done=0, all counters=0 and m_data=0; line-buffer RAM contents are not reset.
REQ-030 SHALL, when rst is asserted mid-frame, abort the frame within 1 cycle with no done pulse; the next cfg_start begins a clean frame.

Structure
REQ-031 SHALL place the FSM state encoding, the stride encoding and the tap-index helper constants in the shared package conv_pkg.
REQ-032 SHALL use a single sub-module, line_buffer_ram (simple dual-port, one read and one write per cycle, depth MAX_LINE, width CH_NUM*DATA_WIDTH), instantiated K-1 times.

Verification
REQ-033 SHALL verify: K=3, line 8, rows 8, stride 1, pixel = row*8+col on all channels -> 36 windows; the first window's taps = {0,1,2,8,9,10,16,17,18}.
REQ-034 SHALL verify: same frame with stride 2 -> 9 windows; the second window's tap 0 = 2; the fourth window's tap 0 = 16.
REQ-035 SHALL verify: m_ready toggled randomly at 50% duty -> an output sequence identical to the no-stall run, with m_data stable during every stall.
REQ-036 SHALL verify: PW mode, 10 pixels with values 1..10 -> 10 outputs with tap 0 = 1..10, all other taps = 0, and done pulsed once.
REQ-037 SHALL verify: rst asserted after 20 pixels of a frame, then a new frame with line 4 and rows 4 -> 4 windows with no stale data and exactly one done.
REQ-038 SHALL verify: line 2, rows 8, K=3 -> 16 inputs accepted, 0 outputs, done pulsed.
